// File: rtl/cordic_pkg.sv
// Shared types and sizing for the CORDIC matrix loader and its row storage.
package cordic_pkg;
  localparam int DATA_W = 12;
  localparam int ROWS   = 32;
  localparam int COLS   = 4;
  localparam int ROW_W  = COLS * DATA_W;
  localparam int ROW_AW = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int WORDS  = ROWS * COLS;
  localparam int CNT_W  = $clog2(WORDS);

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } ld_state_e;
endpackage

// File: rtl/cordic_row_bank.sv
// Two-bank row store: one write port, one registered read port that reads as
// zero when no read is issued, so downstream columns are zero between bursts.
module cordic_row_bank
  import cordic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ROW_AW-1:0] wr_addr,
  input  row_t              wr_row,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ROW_AW-1:0] rd_addr,
  output row_t              rd_row
);
  row_t mem [2*ROWS];
  row_t rd_row_q, rd_row_d;

  // Storage array, no reset: only banks flagged full are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_row;
  end

  // Read mux; idle cycles present zero rather than stale data.
  always_comb begin
    rd_row_d = '0;
    if (rd_en) rd_row_d = mem[{rd_bank, rd_addr}];
  end

  // Read register, cleared asynchronously so a reset truncates the burst at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_row_q <= '0;
    else     rd_row_q <= rd_row_d;
  end

  assign rd_row = rd_row_q;
endmodule

// File: rtl/cordic_matrix_loader.sv
// Ping-pong frame loader: packs a serial word stream into 32x4 frames and
// replays each frame as a contiguous burst, gated by the engine's result burst.
module cordic_matrix_loader
  import cordic_pkg::*;
#(
  parameter int TIMEOUT = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              in_valid,
  output logic [DATA_W-1:0] matrix_0,
  output logic [DATA_W-1:0] matrix_1,
  output logic [DATA_W-1:0] matrix_2,
  output logic [DATA_W-1:0] matrix_3,
  input  logic              eng_valid,
  output logic              timeout_err
);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int SCNT_W = ROW_AW + 1;

  logic                        wr_bank_q, wr_bank_d;
  logic [CNT_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic [1:0]                  full_q, full_d;
  logic [COLS-2:0][DATA_W-1:0] stage_q, stage_d;
  logic                        rd_bank_q, rd_bank_d;
  ld_state_e                   state_q, state_d;
  logic [SCNT_W-1:0]           snd_cnt_q, snd_cnt_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic                        eng_seen_q, eng_seen_d;
  logic                        in_valid_q, in_valid_d;
  logic                        timeout_err_q, timeout_err_d;

  logic              accept, last_word, row_we, rd_en, release_bank;
  logic [COL_W-1:0]  col;
  logic [ROW_AW-1:0] rd_addr;
  row_t              row_wdata, rd_row;

  // s_ready looks at the pre-release full flag; a one-cycle bubble after release is fine.
  assign s_ready   = !rst && !full_q[wr_bank_q];
  assign accept    = s_valid && s_ready;
  assign col       = wr_cnt_q[COL_W-1:0];
  assign last_word = accept && (wr_cnt_q == CNT_W'(WORDS - 1));
  assign row_wdata = {s_data, stage_q};

  // Write side: stage columns 0..2, commit the whole row on column 3.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    stage_d   = stage_q;
    row_we    = 1'b0;
    if (accept) begin
      wr_cnt_d = last_word ? '0 : wr_cnt_q + CNT_W'(1);
      if (col == COL_W'(COLS - 1)) row_we = 1'b1;
      else                         stage_d[col] = s_data;
      if (last_word) wr_bank_d = !wr_bank_q;
    end
  end

  // Bank occupancy: release and fill can hit different banks in the same cycle.
  always_comb begin
    full_d = full_q;
    if (release_bank) full_d[rd_bank_q] = 1'b0;
    if (last_word)    full_d[wr_bank_q] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; a frame completing into the read bank starts the burst next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (full_q[rd_bank_q] || (last_word && (wr_bank_q == rd_bank_q))) state_d = SEND;
      SEND: if (snd_cnt_q == SCNT_W'(ROWS)) state_d = WAIT;
      WAIT: if ((eng_seen_q && !eng_valid) || (tmo_q == TMO_W'(TIMEOUT - 1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: read issue one cycle ahead of in_valid, engine handshake, timeout.
  always_comb begin
    rd_en         = 1'b0;
    rd_addr       = snd_cnt_q[ROW_AW-1:0];
    in_valid_d    = 1'b0;
    snd_cnt_d     = snd_cnt_q;
    tmo_d         = tmo_q;
    eng_seen_d    = eng_seen_q;
    timeout_err_d = 1'b0;
    release_bank  = 1'b0;
    rd_bank_d     = rd_bank_q;
    unique case (state_q)
      IDLE: begin
        if (state_d == SEND) begin
          rd_en      = 1'b1;
          rd_addr    = '0;
          in_valid_d = 1'b1;
          snd_cnt_d  = SCNT_W'(1);
        end
      end
      SEND: begin
        if (snd_cnt_q != SCNT_W'(ROWS)) begin
          rd_en      = 1'b1;
          in_valid_d = 1'b1;
          snd_cnt_d  = snd_cnt_q + SCNT_W'(1);
        end else begin
          tmo_d      = '0;
          eng_seen_d = 1'b0;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (eng_valid) eng_seen_d = 1'b1;
        if (eng_seen_q && !eng_valid) begin
          release_bank = 1'b1;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          release_bank  = 1'b1;
          timeout_err_d = 1'b1;
        end
        if (release_bank) rd_bank_d = !rd_bank_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards buffered frames and any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      full_q        <= '0;
      stage_q       <= '0;
      rd_bank_q     <= 1'b0;
      snd_cnt_q     <= '0;
      tmo_q         <= '0;
      eng_seen_q    <= 1'b0;
      in_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      wr_cnt_q      <= wr_cnt_d;
      full_q        <= full_d;
      stage_q       <= stage_d;
      rd_bank_q     <= rd_bank_d;
      snd_cnt_q     <= snd_cnt_d;
      tmo_q         <= tmo_d;
      eng_seen_q    <= eng_seen_d;
      in_valid_q    <= in_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  cordic_row_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (row_we),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_cnt_q[CNT_W-1:COL_W]),
    .wr_row  (row_wdata),
    .rd_en   (rd_en),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_addr),
    .rd_row  (rd_row)
  );

  assign in_valid    = in_valid_q;
  assign timeout_err = timeout_err_q;
  assign matrix_0    = rd_row[0*DATA_W +: DATA_W];
  assign matrix_1    = rd_row[1*DATA_W +: DATA_W];
  assign matrix_2    = rd_row[2*DATA_W +: DATA_W];
  assign matrix_3    = rd_row[3*DATA_W +: DATA_W];
endmodule

// File: tb/tb_cordic_matrix_loader.sv
// Self-checking bench for cordic_matrix_loader: random frames, burst capture
// monitor, expectations from the word->row/column rule and handshake timing.
module tb_cordic_matrix_loader;
  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_ready, in_valid, eng_valid, timeout_err;
  logic [11:0] s_data, m0, m1, m2, m3;

  always #5 clk = ~clk;

  cordic_matrix_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .in_valid(in_valid), .matrix_0(m0), .matrix_1(m1), .matrix_2(m2), .matrix_3(m3),
    .eng_valid(eng_valid), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [47:0] obs_rows[$];
  int          burst_start[$], burst_len[$], fall_cyc[$], tmo_cyc[$];
  logic [11:0] frames[3][128];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: captures bursts at negedge and checks columns are zero between bursts.
  initial begin : monitor
    bit prev_iv;
    int run_len;
    prev_iv = 1'b0;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (in_valid === 1'b1) begin
        if (!prev_iv) burst_start.push_back(cyc);
        obs_rows.push_back({m3, m2, m1, m0});
        run_len++;
      end else begin
        if (prev_iv) begin
          burst_len.push_back(run_len);
          fall_cyc.push_back(cyc);
          run_len = 0;
        end
        checks++;
        if ({m3, m2, m1, m0} !== 48'd0) begin
          errors++;
          $display("FAIL idle_zero cyc=%0d got=%h need=0", cyc, {m3, m2, m1, m0});
        end
      end
      if (timeout_err === 1'b1) tmo_cyc.push_back(cyc);
      prev_iv = (in_valid === 1'b1);
    end
  end

  function automatic void rand_frame(input int fid);
    logic [31:0] r;
    for (int k = 0; k < 128; k++) begin
      r = $urandom();
      frames[fid][k] = r[11:0];
    end
  endfunction

  function automatic logic [47:0] exp_row(input int fid, input int r);
    return {frames[fid][4*r+3], frames[fid][4*r+2], frames[fid][4*r+1], frames[fid][4*r]};
  endfunction

  // Call at a negedge; returns the negedge cycle just after the last handshake.
  task automatic send_frame(input int fid, input bit gaps, output int last_acc);
    int n;
    last_acc = -1;
    for (int k = 0; k < 128; k++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = frames[fid][k];
      n = 0;
      while (s_ready !== 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2000) begin
        checks++; errors++;
        $display("FAIL send_stall frame=%0d word=%0d got=s_ready_low need=accept", fid, k);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    last_acc = cyc;
    s_valid  = 1'b0;
  endtask

  task automatic wait_bursts(input int n, output bit ok);
    int t;
    t = 0;
    while (burst_len.size() < n && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    ok = (burst_len.size() >= n);
  endtask

  task automatic apply_reset();
    @(negedge clk); #2;
    rst = 1'b1; s_valid = 1'b0; eng_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    obs_rows.delete(); burst_start.delete(); burst_len.delete();
    fall_cyc.delete(); tmo_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 12'hABC; eng_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b need=0", s_ready); end
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL rst_in_valid got=%b need=0", in_valid); end
    checks++; if ({m3, m2, m1, m0} !== 48'd0) begin errors++; $display("FAIL rst_matrix got=%h need=0", {m3, m2, m1, m0}); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got=%b need=0", timeout_err); end
    s_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_s_ready got=%b need=1", s_ready); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (obs_rows.size() != 0) begin errors++; $display("FAIL post_rst_no_burst got=%0d need=0", obs_rows.size()); end
  endtask

  // Words 0..127 straight after reset (no extra reset: a word written during
  // reset would shift every row and start the burst early).
  task automatic test_stream();
    int la; bit ok;
    for (int k = 0; k < 128; k++) frames[0][k] = 12'(k);
    @(negedge clk);
    send_frame(0, 1'b0, la);
    wait_bursts(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stream_burst got=none need=1"); return; end
    checks++; if (burst_start[0] != la) begin errors++; $display("FAIL stream_start got=%0d need=%0d", burst_start[0], la); end
    checks++; if (burst_len[0] != 32) begin errors++; $display("FAIL stream_len got=%0d need=32", burst_len[0]); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (obs_rows[r] !== exp_row(0, r)) begin
        errors++; $display("FAIL stream_row%0d got=%h need=%h", r, obs_rows[r], exp_row(0, r));
      end
    end
  endtask

  task automatic test_signs();
    int la; bit ok;
    apply_reset();
    rand_frame(0);
    frames[0][0] = 12'h800; frames[0][1] = 12'hFFF; frames[0][2] = 12'h7FF;
    send_frame(0, 1'b1, la);
    wait_bursts(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL signs_burst got=none need=1"); return; end
    checks++; if (burst_start[0] != la) begin errors++; $display("FAIL signs_start got=%0d need=%0d", burst_start[0], la); end
    checks++; if (obs_rows[0][11:0] !== 12'h800) begin errors++; $display("FAIL signs_m0 got=%h need=800", obs_rows[0][11:0]); end
    checks++; if (obs_rows[0][23:12] !== 12'hFFF) begin errors++; $display("FAIL signs_m1 got=%h need=fff", obs_rows[0][23:12]); end
    checks++; if (obs_rows[0][35:24] !== 12'h7FF) begin errors++; $display("FAIL signs_m2 got=%h need=7ff", obs_rows[0][35:24]); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (obs_rows[r] !== exp_row(0, r)) begin
        errors++; $display("FAIL signs_row%0d got=%h need=%h", r, obs_rows[r], exp_row(0, r));
      end
    end
  endtask

  task automatic test_back_to_back();
    int la_a, la_b, la_c, n1, n2; bit ok;
    apply_reset();
    rand_frame(0); rand_frame(1); rand_frame(2);
    send_frame(0, 1'b0, la_a);
    send_frame(1, 1'b0, la_b);
    wait_bursts(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_burstA got=none need=1"); return; end
    checks++; if (burst_start[0] != la_a) begin errors++; $display("FAIL b2b_startA got=%0d need=%0d", burst_start[0], la_a); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_both_full got=%b need=0", s_ready); end
    eng_valid = 1'b1;
    repeat (31) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_during_eng got=%b need=0", s_ready); end
    eng_valid = 1'b0;
    n1 = cyc;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_freed got=%b need=1", s_ready); end
    wait_bursts(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_burstB got=none need=2"); return; end
    checks++; if (burst_start[1] != n1 + 2) begin errors++; $display("FAIL b2b_startB got=%0d need=%0d", burst_start[1], n1 + 2); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (obs_rows[32+r] !== exp_row(1, r)) begin
        errors++; $display("FAIL b2b_B_row%0d got=%h need=%h", r, obs_rows[32+r], exp_row(1, r));
      end
    end
    send_frame(2, 1'b0, la_c);
    eng_valid = 1'b1;
    repeat (31) @(negedge clk);
    eng_valid = 1'b0;
    n2 = cyc;
    wait_bursts(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_burstC got=none need=3"); return; end
    checks++; if (burst_start[2] != n2 + 2) begin errors++; $display("FAIL b2b_startC got=%0d need=%0d", burst_start[2], n2 + 2); end
    checks++; if (burst_len[2] != 32) begin errors++; $display("FAIL b2b_lenC got=%0d need=32", burst_len[2]); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (obs_rows[64+r] !== exp_row(2, r)) begin
        errors++; $display("FAIL b2b_C_row%0d got=%h need=%h", r, obs_rows[64+r], exp_row(2, r));
      end
    end
    checks++; if (tmo_cyc.size() != 0) begin errors++; $display("FAIL b2b_no_timeout got=%0d need=0", tmo_cyc.size()); end
  endtask

  task automatic test_timeout();
    int la_a, la_b, t; bit ok;
    apply_reset();
    rand_frame(0); rand_frame(1);
    send_frame(0, 1'b0, la_a);
    wait_bursts(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_burstA got=none need=1"); return; end
    send_frame(1, 1'b0, la_b);
    t = 0;
    while (tmo_cyc.size() < 1 && t < 600) begin
      @(negedge clk); #1;
      t++;
    end
    checks++; if (tmo_cyc.size() < 1) begin errors++; $display("FAIL tmo_pulse got=none need=1"); return; end
    checks++;
    if (tmo_cyc[0] - fall_cyc[0] != TMO) begin
      errors++; $display("FAIL tmo_delay got=%0d need=%0d", tmo_cyc[0] - fall_cyc[0], TMO);
    end
    wait_bursts(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_burstB got=none need=2"); return; end
    checks++; if (tmo_cyc.size() != 1) begin errors++; $display("FAIL tmo_width got=%0d need=1", tmo_cyc.size()); end
    checks++; if (burst_start[1] != tmo_cyc[0] + 1) begin errors++; $display("FAIL tmo_startB got=%0d need=%0d", burst_start[1], tmo_cyc[0] + 1); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (obs_rows[32+r] !== exp_row(1, r)) begin
        errors++; $display("FAIL tmo_B_row%0d got=%h need=%h", r, obs_rows[32+r], exp_row(1, r));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int la, t; bit ok;
    apply_reset();
    rand_frame(0); rand_frame(1);
    send_frame(0, 1'b0, la);
    t = 0;
    while (obs_rows.size() < 10 && t < 1000) begin
      @(negedge clk); #1;
      t++;
    end
    checks++; if (obs_rows.size() < 10) begin errors++; $display("FAIL mid_burst_start got=%0d need=10", obs_rows.size()); return; end
    #1 rst = 1'b1;
    #1;
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_in_valid got=%b need=0", in_valid); end
    checks++; if ({m3, m2, m1, m0} !== 48'd0) begin errors++; $display("FAIL mid_rst_matrix got=%h need=0", {m3, m2, m1, m0}); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_ready got=%b need=0", s_ready); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (burst_len.size() != 1 || burst_len[0] != 10) begin
      errors++; $display("FAIL mid_rst_truncate got=%0d need=10", (burst_len.size() > 0) ? burst_len[0] : -1);
    end
    #1 rst = 1'b0;
    @(negedge clk); #1;
    obs_rows.delete(); burst_start.delete(); burst_len.delete();
    fall_cyc.delete(); tmo_cyc.delete();
    send_frame(1, 1'b0, la);
    wait_bursts(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_rst_fresh got=none need=1"); return; end
    checks++; if (burst_start[0] != la) begin errors++; $display("FAIL mid_rst_start got=%0d need=%0d", burst_start[0], la); end
    checks++; if (burst_len[0] != 32) begin errors++; $display("FAIL mid_rst_len got=%0d need=32", burst_len[0]); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (obs_rows[r] !== exp_row(1, r)) begin
        errors++; $display("FAIL mid_rst_row%0d got=%h need=%h", r, obs_rows[r], exp_row(1, r));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_signs();
    test_back_to_back();
    test_timeout();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
